// File: rtl/verificador_compuertas_pkg.sv
// Shared definitions for the gate-test response checker: FSM state encoding
// and default widths.
package verificador_compuertas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } estado_t;

    localparam int WIDTH_DEF = 3;
    localparam int CNT_W_DEF = 8;

    // Reduction-OR of a sample difference word, kept as a helper so the FSM reads cleanly.
    function automatic logic hay_fallo(input logic [31:0] diff_word);
        return |diff_word;
    endfunction

endpackage

// File: rtl/verificador_compuertas_contador_saturado.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module contador_saturado #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count register: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= {CNT_W{1'b0}};
        end else if (clr) begin
            count <= {CNT_W{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/verificador_compuertas.sv
// Self-checking responder: compares expected vs obtained gate outputs per
// sample, tracks counts and the first failure, and reports PASS/FAIL.
module verificador_compuertas
    import verificador_compuertas_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             start,
    input  logic             valid,
    input  logic             last,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] got,
    output logic             busy,
    output logic             mismatch,
    output logic             error,
    output logic [WIDTH-1:0] first_mask,
    output logic [CNT_W-1:0] first_idx,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] error_count,
    output logic             done,
    output logic             pass
);

    estado_t          state_r;
    logic [WIDTH-1:0] diff_s;
    logic             fallo_s;
    logic             muestra_s;
    logic             clr_s;
    logic             inc_err_s;

    // Per-sample difference and counter controls; a restart clears the counters on the entering edge.
    always_comb begin
        diff_s    = exp ^ got;
        fallo_s   = hay_fallo(32'(diff_s));
        muestra_s = (state_r == ST_RUN) && valid;
        clr_s     = start && (state_r != ST_RUN);
        inc_err_s = muestra_s && fallo_s;
    end

    contador_saturado #(.CNT_W(CNT_W)) u_cnt_muestras (
        .clk     (clk),
        .reset_L (reset_L),
        .clr     (clr_s),
        .inc     (muestra_s),
        .count   (sample_count)
    );

    contador_saturado #(.CNT_W(CNT_W)) u_cnt_errores (
        .clk     (clk),
        .reset_L (reset_L),
        .clr     (clr_s),
        .inc     (inc_err_s),
        .count   (error_count)
    );

    // Run-control FSM with registered status flags and first-failure capture.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            error      <= 1'b0;
            mismatch   <= 1'b0;
            first_mask <= {WIDTH{1'b0}};
            first_idx  <= {CNT_W{1'b0}};
        end else begin
            mismatch <= inc_err_s;
            case (state_r)
                ST_RUN: begin
                    if (valid) begin
                        if (fallo_s) begin
                            error <= 1'b1;
                            // sample_count is still the pre-increment index here
                            if (!error) begin
                                first_mask <= diff_s;
                                first_idx  <= sample_count;
                            end
                        end
                        if (last) begin
                            state_r <= (error || fallo_s) ? ST_FAIL : ST_PASS;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= !(error || fallo_s);
                        end
                    end
                end
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (start) begin
                        state_r    <= ST_RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        error      <= 1'b0;
                        first_mask <= {WIDTH{1'b0}};
                        first_idx  <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

endmodule
